// File: rtl/fifo_queue.sv
// fifo_queue: 16 x 11 register-based first-in-first-out queue.
// Writes enter at the tail and reads drain from the head. Read data is
// registered with a one-cycle valid strobe. Occupancy drives full/empty,
// and sticky overflow/underflow flags record refused requests.
module fifo_queue #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_acc;
    logic              w_wr_acc;

    // Status and accept decisions come only from registered occupancy.
    // A write into a full queue is accepted when a read frees the head
    // slot in the same cycle; a read from an empty queue is never bypassed.
    always_comb begin
        w_full   = (r_count == CNT_FULL);
        w_empty  = (r_count == '0);
        w_rd_acc = rd_en && !w_empty;
        w_wr_acc = wr_en && (!w_full || w_rd_acc);
    end

    // Storage array write; the array itself is not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, registered read data and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            // When full with a simultaneous write, wr_ptr equals rd_ptr; the
            // non-blocking read below still returns the old head word.
            if (w_rd_acc) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_dout_valid <= w_rd_acc;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue: directed stimulus with a scoreboard queue of expected pops,
// drained by an independent monitor whenever dout_valid is high.
module tb_fifo_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [10:0] din;
    logic [10:0] dout;
    logic        dout_valid;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] sb[$];

    fifo_queue #(.DATA_W(11), .DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the oldest expected entry.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%0h expected no output", dout);
            end else begin
                chk("dout_order", int'(dout), int'(sb.pop_front()));
            end
        end
    end

    task automatic step(input logic w, input logic r, input logic [10:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int c, input int f,
                              input int e, input int ov, input int un);
        chk({tag, "_count"},     int'(count),     c);
        chk({tag, "_full"},      int'(full),      f);
        chk({tag, "_empty"},     int'(empty),     e);
        chk({tag, "_overflow"},  int'(overflow),  ov);
        chk({tag, "_underflow"}, int'(underflow), un);
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, '0);

        // Reset then idle.
        chk_status("reset", 0, 0, 1, 0, 0);
        chk("reset_dout",       int'(dout),       0);
        chk("reset_dout_valid", int'(dout_valid), 0);

        // Fill with 0x001..0x010.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 11'(i));
            chk("fill_count", int'(count), i);
        end
        chk_status("filled", 16, 1, 0, 0, 0);

        // Refused write while full.
        step(1'b1, 1'b0, 11'h7FF);
        chk_status("ovf", 16, 1, 0, 1, 0);

        // Drain: 0x001..0x010 in order, no 0x7FF.
        for (int i = 1; i <= 16; i++) begin
            sb.push_back(11'(i));
            step(1'b0, 1'b1, '0);
            chk("drain_valid", int'(dout_valid), 1);
            chk("drain_count", int'(count), 16 - i);
        end
        step(1'b0, 1'b0, '0);
        chk_status("drained", 0, 0, 1, 1, 0);
        chk("drained_valid_low", int'(dout_valid), 0);

        // Full with simultaneous write+read for 20 cycles, across wrap.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 11'(12'h100 + i));
        end
        chk_status("refill", 16, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            sb.push_back((i < 16) ? 11'(12'h101 + i) : 11'h555);
            step(1'b1, 1'b1, 11'h555);
            chk("simul_full_count", int'(count), 16);
        end
        chk_status("simul_full", 16, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            sb.push_back(11'h555);
            step(1'b0, 1'b1, '0);
        end
        step(1'b0, 1'b0, '0);
        chk_status("simul_drained", 0, 0, 1, 0, 0);

        // Simultaneous write+read while empty: read refused, write taken.
        step(1'b1, 1'b1, 11'h123);
        chk("empty_wr_rd_valid", int'(dout_valid), 0);
        chk_status("empty_wr_rd", 1, 0, 0, 0, 1);
        sb.push_back(11'h123);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        chk_status("after_123", 0, 0, 1, 0, 1);

        // Refused read from empty holds dout.
        step(1'b0, 1'b1, '0);
        chk("empty_read_valid", int'(dout_valid), 0);
        chk("empty_read_dout",  int'(dout),       11'h123);

        // Reset mid-stream discards contents.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 11'(12'h200 + i));
        end
        chk("pre_rst_count", int'(count), 5);
        do_reset();
        chk_status("mid_rst", 0, 0, 1, 0, 0);
        chk("mid_rst_dout", int'(dout), 0);
        step(1'b1, 1'b0, 11'h0AA);
        chk("post_rst_count", int'(count), 1);
        sb.push_back(11'h0AA);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        chk_status("post_rst_drain", 0, 0, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
